// File: rtl/lap_timer.sv
// Race lap timer: counts centiseconds from a start pulse, closes laps on finish-line
// rising edges, and keeps last/best lap times plus the lap count until the race ends.
module lap_timer #(
   parameter int unsigned CLK_FREQ_HZ = 65_000_000,
   parameter int unsigned TICK_HZ     = 100,
   parameter int unsigned MAX_TIME    = 59999,
   parameter int unsigned MIN_LAP     = 300,
   parameter int unsigned LAPS        = 3
) (
   input  logic        pclk,
   input  logic        rst_n,
   input  logic        race_start,
   input  logic        pause,
   input  logic        finish_line,
   output logic [15:0] current_lap_time,
   output logic [15:0] last_lap_time,
   output logic [15:0] best_lap_time,
   output logic        best_valid,
   output logic [3:0]  lap_count,
   output logic        new_lap,
   output logic        race_done
);

   localparam int unsigned DIV = CLK_FREQ_HZ / TICK_HZ;
   localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

   typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, FINISHED} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [15:0]   cur_q, cur_d;
   logic [15:0]   last_q, last_d;
   logic [15:0]   best_q, best_d;
   logic          best_valid_q, best_valid_d;
   logic [3:0]    lap_cnt_q, lap_cnt_d;
   logic          new_lap_q, new_lap_d;
   logic          line_q, line_d;

   logic       crossing, tick;
   logic [3:0] lap_inc;

   assign crossing = finish_line & ~line_q;
   assign tick     = (pre_q == PRE_MAX);
   assign lap_inc  = lap_cnt_q + 4'd1;

   always_comb begin
      state_d      = state_q;
      pre_d        = pre_q;
      cur_d        = cur_q;
      last_d       = last_q;
      best_d       = best_q;
      best_valid_d = best_valid_q;
      lap_cnt_d    = lap_cnt_q;
      new_lap_d    = 1'b0;
      line_d       = finish_line;

      if (race_start) begin
         state_d      = RUNNING;
         pre_d        = '0;
         cur_d        = '0;
         last_d       = '0;
         best_d       = '0;
         best_valid_d = 1'b0;
         lap_cnt_d    = '0;
      end else begin
         case (state_q)
            RUNNING: begin
               if (crossing && cur_q >= 16'(MIN_LAP)) begin
                  // Lap closes on the pre-tick value; a coincident tick is discarded.
                  last_d       = cur_q;
                  new_lap_d    = 1'b1;
                  lap_cnt_d    = lap_inc;
                  best_valid_d = 1'b1;
                  if (!best_valid_q || cur_q < best_q)
                     best_d = cur_q;
                  if (lap_inc == 4'(LAPS)) begin
                     state_d = FINISHED;
                  end else begin
                     cur_d = '0;
                     pre_d = '0;
                     if (pause)
                        state_d = PAUSED;
                  end
               end else begin
                  if (tick) begin
                     pre_d = '0;
                     if (cur_q < 16'(MAX_TIME))
                        cur_d = cur_q + 16'd1;
                  end else begin
                     pre_d = pre_q + PW'(1);
                  end
                  if (pause)
                     state_d = PAUSED;
               end
            end
            PAUSED: begin
               if (!pause)
                  state_d = RUNNING;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         pre_q        <= '0;
         cur_q        <= '0;
         last_q       <= '0;
         best_q       <= '0;
         best_valid_q <= 1'b0;
         lap_cnt_q    <= '0;
         new_lap_q    <= 1'b0;
         line_q       <= 1'b1; // a car parked on the line at reset must not count as a crossing
      end else begin
         state_q      <= state_d;
         pre_q        <= pre_d;
         cur_q        <= cur_d;
         last_q       <= last_d;
         best_q       <= best_d;
         best_valid_q <= best_valid_d;
         lap_cnt_q    <= lap_cnt_d;
         new_lap_q    <= new_lap_d;
         line_q       <= line_d;
      end
   end

   assign current_lap_time = cur_q;
   assign last_lap_time    = last_q;
   assign best_lap_time    = best_q;
   assign best_valid       = best_valid_q;
   assign lap_count        = lap_cnt_q;
   assign new_lap          = new_lap_q;
   assign race_done        = (state_q == FINISHED);

endmodule

// File: tb/tb_lap_timer.sv
// Directed bench for lap_timer: 10 clocks per tick, MIN_LAP=3, LAPS=3, and a reduced
// saturation ceiling of 500 so the saturation scenario fits in a short run.
module tb_lap_timer;

   localparam int unsigned SAT = 500;

   logic        pclk = 1'b0;
   logic        rst_n = 1'b0;
   logic        race_start = 1'b0;
   logic        pause = 1'b0;
   logic        finish_line = 1'b0;
   logic [15:0] cur, last, best;
   logic        best_valid, new_lap, race_done;
   logic [3:0]  lap_count;

   int n_chk  = 0;
   int n_pass = 0;

   lap_timer #(
      .CLK_FREQ_HZ(1000), .TICK_HZ(100), .MAX_TIME(SAT), .MIN_LAP(3), .LAPS(3)
   ) dut (
      .pclk(pclk), .rst_n(rst_n), .race_start(race_start), .pause(pause),
      .finish_line(finish_line), .current_lap_time(cur), .last_lap_time(last),
      .best_lap_time(best), .best_valid(best_valid), .lap_count(lap_count),
      .new_lap(new_lap), .race_done(race_done)
   );

   always #5 pclk = ~pclk;

   task automatic step(input int n);
      repeat (n) @(posedge pclk);
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
      else n_pass++;
   endtask

   task automatic test_reset;
      step(3);
      chk("reset_cur", cur, 16'd0);
      chk("reset_last", last, 16'd0);
      chk("reset_best", best, 16'd0);
      chk("reset_flags", {12'd0, best_valid, new_lap, race_done, 1'b0}, 16'd0);
      chk("reset_laps", {12'd0, lap_count}, 16'd0);
      rst_n = 1'b1;
      step(5);
      chk("idle_cur", cur, 16'd0);
   endtask

   task automatic test_run;
      race_start = 1'b1; step(1); race_start = 1'b0;
      step(250);
      chk("run_cur25", cur, 16'd25);
      chk("run_laps0", {12'd0, lap_count}, 16'd0);
      chk("run_not_done", {15'd0, race_done}, 16'd0);
   endtask

   task automatic test_min_lap;
      race_start = 1'b1; step(1); race_start = 1'b0;
      chk("restart_cur0", cur, 16'd0);
      step(20);
      chk("min_cur2", cur, 16'd2);
      finish_line = 1'b1; step(1); finish_line = 1'b0; step(1);
      chk("short_lap_ignored_cnt", {12'd0, lap_count}, 16'd0);
      chk("short_lap_ignored_last", last, 16'd0);
      step(48);
      chk("min_cur7", cur, 16'd7);
      finish_line = 1'b1; step(1);
      chk("lap1_last", last, 16'd7);
      chk("lap1_best", best, 16'd7);
      chk("lap1_valid", {15'd0, best_valid}, 16'd1);
      chk("lap1_pulse", {15'd0, new_lap}, 16'd1);
      chk("lap1_cnt", {12'd0, lap_count}, 16'd1);
      chk("lap1_cur0", cur, 16'd0);
      finish_line = 1'b0; step(1);
      chk("lap1_pulse_end", {15'd0, new_lap}, 16'd0);
   endtask

   task automatic test_pause;
      // Lap has 1 counted edge; 34 more gives cur=3 with 5 clocks into the period.
      step(34);
      chk("pre_pause_cur", cur, 16'd3);
      pause = 1'b1; step(1);   // entry edge still counts: 6 clocks into the period
      step(100);
      chk("paused_cur", cur, 16'd3);
      pause = 1'b0; step(1);   // leaving PAUSED holds for this edge
      step(3);
      chk("resume_no_tick_yet", cur, 16'd3);
      step(1);
      chk("resume_tick", cur, 16'd4);
   endtask

   task automatic test_finish;
      step(50);
      chk("lap2_pre", cur, 16'd9);
      finish_line = 1'b1; step(1);
      chk("lap2_last", last, 16'd9);
      chk("lap2_best_kept", best, 16'd7);
      chk("lap2_cnt", {12'd0, lap_count}, 16'd2);
      finish_line = 1'b0; step(1);
      step(49);
      chk("lap3_pre", cur, 16'd5);
      finish_line = 1'b1; step(1);
      chk("lap3_last", last, 16'd5);
      chk("lap3_best", best, 16'd5);
      chk("lap3_cnt", {12'd0, lap_count}, 16'd3);
      chk("lap3_done", {15'd0, race_done}, 16'd1);
      chk("lap3_frozen", cur, 16'd5);
      finish_line = 1'b0; step(30);
      chk("frozen_cur", cur, 16'd5);
      chk("frozen_pulse", {15'd0, new_lap}, 16'd0);
      finish_line = 1'b1; step(1); finish_line = 1'b0; pause = 1'b1; step(5); pause = 1'b0; step(2);
      chk("done_ignores_cnt", {12'd0, lap_count}, 16'd3);
      chk("done_ignores_last", last, 16'd5);
      chk("done_ignores_state", {15'd0, race_done}, 16'd1);
   endtask

   task automatic test_saturate;
      race_start = 1'b1; step(1); race_start = 1'b0;
      chk("fin_restart_cnt", {12'd0, lap_count}, 16'd0);
      chk("fin_restart_valid", {15'd0, best_valid}, 16'd0);
      chk("fin_restart_best", best, 16'd0);
      chk("fin_restart_last", last, 16'd0);
      chk("fin_restart_done", {15'd0, race_done}, 16'd0);
      step(SAT * 10 + 200);
      chk("sat_cur", cur, 16'(SAT));
      finish_line = 1'b1; step(1); finish_line = 1'b0;
      chk("sat_last", last, 16'(SAT));
      chk("sat_cnt", {12'd0, lap_count}, 16'd1);
      chk("sat_cur0", cur, 16'd0);
   endtask

   task automatic test_line_through_reset;
      finish_line = 1'b1;
      rst_n = 1'b0; step(2); rst_n = 1'b1; step(1);
      race_start = 1'b1; step(1); race_start = 1'b0;
      step(100);
      chk("parked_cnt", {12'd0, lap_count}, 16'd0);
      chk("parked_cur", cur, 16'd10);
      finish_line = 1'b0; step(1);
   endtask

   task automatic test_cross_tick;
      // 101 counted edges: 8 more puts the prescaler at its last count.
      step(8);
      chk("ct_pre", cur, 16'd10);
      finish_line = 1'b1; step(1);
      chk("ct_last_pretick", last, 16'd10);
      chk("ct_cur0", cur, 16'd0);
      finish_line = 1'b0; step(9);
      chk("ct_presc_cleared", cur, 16'd0);
      step(1);
      chk("ct_first_tick", cur, 16'd1);
   endtask

   task automatic test_start_vs_cross;
      step(30);
      chk("sc_pre", cur, 16'd4);
      finish_line = 1'b1; race_start = 1'b1; step(1);
      race_start = 1'b0; finish_line = 1'b0;
      chk("sc_cnt", {12'd0, lap_count}, 16'd0);
      chk("sc_last", last, 16'd0);
      chk("sc_pulse", {15'd0, new_lap}, 16'd0);
      chk("sc_cur", cur, 16'd0);
   endtask

   task automatic test_async_reset;
      step(70);
      finish_line = 1'b1; step(1); finish_line = 1'b0; step(20);
      chk("ar_pre_cnt", {12'd0, lap_count}, 16'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_cur", cur, 16'd0);
      chk("ar_last", last, 16'd0);
      chk("ar_best", best, 16'd0);
      chk("ar_cnt", {12'd0, lap_count}, 16'd0);
      chk("ar_flags", {13'd0, best_valid, new_lap, race_done}, 16'd0);
      step(2); rst_n = 1'b1; step(20);
      chk("ar_idle", cur, 16'd0);
   endtask

   initial begin
      test_reset();
      test_run();
      test_min_lap();
      test_pause();
      test_finish();
      test_saturate();
      test_line_through_reset();
      test_cross_tick();
      test_start_vs_cross();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
